// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue in front of a variable-latency memory.
// It keeps at most one request outstanding, squashes stale responses on redirect and presents the queue head to decode.
module if_prefetch_stage #(
  parameter int                  WORD_LEN   = 16,
  parameter int                  PC_STEP    = 2,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [WORD_LEN-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                brTaken,
  input  logic                jump_en,
  input  logic [WORD_LEN-1:0] brOffset,
  input  logic                freeze,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rsp_valid,
  input  logic [WORD_LEN-1:0] imem_rsp_data,
  output logic [WORD_LEN-1:0] PC,
  output logic [WORD_LEN-1:0] instruction,
  output logic                inst_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WORD_LEN-1:0] STEP = WORD_LEN'(PC_STEP);
  localparam logic [CNT_W-1:0]    FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} reqState_t;

  reqState_t           state, stateNext;
  logic [WORD_LEN-1:0] fetchPc;
  logic [WORD_LEN-1:0] reqTag;
  logic [WORD_LEN-1:0] pcQ   [FIFO_DEPTH];
  logic [WORD_LEN-1:0] wordQ [FIFO_DEPTH];
  logic [PTR_W-1:0]    rdPtr, wrPtr;
  logic [CNT_W-1:0]    count;
  logic                redirect, issue, push, pop;
  logic [WORD_LEN-1:0] offsetShift, target;

  // Offsets count instruction words; the shift drops the MSB so targets wrap.
  assign redirect    = jump_en | brTaken;
  assign offsetShift = {brOffset[WORD_LEN-2:0], 1'b0};
  assign target      = jump_en ? offsetShift : (PC + STEP + offsetShift);

  assign inst_valid  = (count != '0);
  assign PC          = inst_valid ? pcQ[rdPtr] : fetchPc;
  assign instruction = inst_valid ? wordQ[rdPtr] : '0;
  assign imem_addr   = fetchPc;
  assign pop         = inst_valid & ~freeze & ~redirect;

  always_comb begin
    stateNext = state;
    imem_req  = 1'b0;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        // No request is outstanding here, so any free slot is already reserved for its response.
        imem_req = ~rst & ~redirect & (count < FULL);
        if (imem_req && imem_gnt) begin
          issue     = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          push      = ~redirect;
          stateNext = IDLE;
        end else if (redirect) begin
          stateNext = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fetchPc <= RESET_PC;
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
    end else begin
      state <= stateNext;
      if (redirect) begin
        fetchPc <= target;
        count   <= '0;
        rdPtr   <= '0;
        wrPtr   <= '0;
      end else begin
        if (issue) fetchPc <= fetchPc + STEP;
        if (push)  wrPtr   <= wrPtr + PTR_W'(1);
        if (pop)   rdPtr   <= rdPtr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage and request tag carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (issue) reqTag <= fetchPc;
    if (push) begin
      pcQ[wrPtr]   <= reqTag;
      wordQ[wrPtr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: cycle vector table, directed redirect/reset sequences, then
// randomized traffic against a queue-based reference model and a variable-latency memory.
module tb_if_prefetch_stage;

  localparam int          DEPTH = 4;
  localparam logic [15:0] STEP  = 16'd2;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, brTaken, jump_en, freeze;
  logic        imem_req, imem_gnt, imem_rsp_valid, inst_valid;
  logic [15:0] brOffset, imem_addr, imem_rsp_data, PC, instruction;

  always #5 clk = ~clk;

  if_prefetch_stage #(.WORD_LEN(16), .PC_STEP(2), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .brTaken(brTaken), .jump_en(jump_en), .brOffset(brOffset),
    .freeze(freeze), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .PC(PC),
    .instruction(instruction), .inst_valid(inst_valid)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  bit          rstI, brI, jmpI, frzI, gntI;
  logic [15:0] offI;

  // Memory environment: one response per grant, latency drawn per grant
  bit          memBusy;
  int          memWait, memLatMin, memLatMax;
  logic [15:0] memAddr, memXor;

  // Reference model: queue of fetched {pc, word}
  typedef struct { logic [15:0] pc; logic [15:0] word; } ent_t;
  ent_t        mQ[$];
  logic [15:0] mFetch, mTag;
  bit          mOut, mDrop;

  // Outputs sampled at the falling edge
  logic        sReq, sValid;
  logic [15:0] sAddr, sPc, sInst;

  task automatic doCycle(input bit chk);
    bit          expReq, redir, rspV, hasHead;
    logic [15:0] expPc, expInst, tgt, offSh;
    rst = rstI; brTaken = brI; jump_en = jmpI; brOffset = offI; freeze = frzI; imem_gnt = gntI;
    rspV = memBusy && (memWait == 0);
    imem_rsp_valid = rspV;
    imem_rsp_data  = rspV ? (memAddr ^ memXor) : 16'hBEEF;
    @(negedge clk);
    sReq = imem_req; sAddr = imem_addr; sValid = inst_valid; sPc = PC; sInst = instruction;

    redir   = brI | jmpI;
    hasHead = (mQ.size() > 0);
    expReq  = !rstI && !mOut && (mQ.size() < DEPTH) && !redir;
    expPc   = hasHead ? mQ[0].pc : mFetch;
    expInst = hasHead ? mQ[0].word : 16'h0000;
    if (chk) begin
      check("model_req",   sReq,   expReq);
      check("model_addr",  sAddr,  mFetch);
      check("model_valid", sValid, hasHead);
      check("model_pc",    sPc,    expPc);
      check("model_inst",  sInst,  expInst);
    end

    if (rstI) begin
      mQ.delete(); mFetch = RPC; mOut = 0; mDrop = 0;
    end else if (redir) begin
      offSh = offI << 1;
      tgt = jmpI ? offSh : (expPc + STEP + offSh);
      mQ.delete();
      mFetch = tgt;
      if (mOut) begin
        if (rspV) begin mOut = 0; mDrop = 0; end
        else mDrop = 1;
      end
    end else begin
      if (hasHead && !frzI) void'(mQ.pop_front());
      if (mOut) begin
        if (rspV) begin
          if (!mDrop) mQ.push_back('{pc: mTag, word: imem_rsp_data});
          mOut = 0; mDrop = 0;
        end
      end else if (expReq && gntI) begin
        mOut = 1; mTag = mFetch; mFetch = mFetch + STEP;
      end
    end

    if (rstI) memBusy = 0;
    else begin
      if (memBusy) begin
        if (rspV) memBusy = 0;
        else memWait--;
      end
      if (sReq && gntI) begin
        memBusy = 1;
        memWait = int'($urandom_range(memLatMax, memLatMin)) - 1;
        memAddr = sAddr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst; bit br; bit jmp; bit frz; logic [15:0] off;
    bit req; logic [15:0] addr; bit vld; logic [15:0] pc; logic [15:0] inst;
  } vec_t;
  vec_t vecs[24];

  initial begin
    int n;
    // rst br jmp frz off | req addr vld pc inst   (zero-wait memory, word = address)
    vecs[0]  = '{1,0,0,0,16'h0,  0,16'h00,0,16'h00,16'h00};
    vecs[1]  = '{0,0,0,0,16'h0,  1,16'h00,0,16'h00,16'h00};
    vecs[2]  = '{0,0,0,0,16'h0,  0,16'h02,0,16'h02,16'h00};
    vecs[3]  = '{0,0,0,0,16'h0,  1,16'h02,1,16'h00,16'h00};
    vecs[4]  = '{0,0,0,0,16'h0,  0,16'h04,0,16'h04,16'h00};
    vecs[5]  = '{0,0,0,1,16'h0,  1,16'h04,1,16'h02,16'h02};
    vecs[6]  = '{0,0,0,1,16'h0,  0,16'h06,1,16'h02,16'h02};
    vecs[7]  = '{0,0,0,1,16'h0,  1,16'h06,1,16'h02,16'h02};
    vecs[8]  = '{0,0,0,1,16'h0,  0,16'h08,1,16'h02,16'h02};
    vecs[9]  = '{0,0,0,1,16'h0,  1,16'h08,1,16'h02,16'h02};
    vecs[10] = '{0,0,0,1,16'h0,  0,16'h0A,1,16'h02,16'h02};
    vecs[11] = '{0,0,0,1,16'h0,  0,16'h0A,1,16'h02,16'h02};
    vecs[12] = '{0,0,0,1,16'h0,  0,16'h0A,1,16'h02,16'h02};
    vecs[13] = '{0,0,0,0,16'h0,  0,16'h0A,1,16'h02,16'h02};
    vecs[14] = '{0,0,0,0,16'h0,  1,16'h0A,1,16'h04,16'h04};
    vecs[15] = '{0,0,0,0,16'h0,  0,16'h0C,1,16'h06,16'h06};
    vecs[16] = '{0,0,0,0,16'h0,  1,16'h0C,1,16'h08,16'h08};
    vecs[17] = '{0,1,0,0,16'h3,  0,16'h0E,1,16'h0A,16'h0A};
    vecs[18] = '{0,0,0,0,16'h0,  1,16'h12,0,16'h12,16'h00};
    vecs[19] = '{0,0,0,0,16'h0,  0,16'h14,0,16'h14,16'h00};
    vecs[20] = '{0,1,1,0,16'h40, 0,16'h14,1,16'h12,16'h12};
    vecs[21] = '{0,0,0,0,16'h0,  1,16'h80,0,16'h80,16'h00};
    vecs[22] = '{0,0,0,0,16'h0,  0,16'h82,0,16'h82,16'h00};
    vecs[23] = '{0,0,0,0,16'h0,  1,16'h82,1,16'h80,16'h80};

    rstI = 1; brI = 0; jmpI = 0; frzI = 0; gntI = 1; offI = '0;
    memBusy = 0; memWait = 0; memLatMin = 1; memLatMax = 1; memXor = '0; memAddr = '0;
    mFetch = RPC; mTag = '0; mOut = 0; mDrop = 0;
    doCycle(0);

    for (int i = 0; i < 24; i++) begin
      rstI = vecs[i].rst; brI = vecs[i].br; jmpI = vecs[i].jmp; frzI = vecs[i].frz; offI = vecs[i].off;
      doCycle(0);
      check($sformatf("vec%0d_req", i),   sReq,   vecs[i].req);
      check($sformatf("vec%0d_addr", i),  sAddr,  vecs[i].addr);
      check($sformatf("vec%0d_valid", i), sValid, vecs[i].vld);
      check($sformatf("vec%0d_pc", i),    sPc,    vecs[i].pc);
      check($sformatf("vec%0d_inst", i),  sInst,  vecs[i].inst);
    end
    brI = 0; jmpI = 0; frzI = 0; offI = '0;

    // Branch taken while head PC is 0x0010, offset 3 words
    rstI = 1; doCycle(1); rstI = 0;
    n = 0;
    while (!(mQ.size() > 0 && mQ[0].pc == 16'h0010) && n < 60) begin doCycle(1); n++; end
    check("brA_reach", n < 60, 1'b1);
    brI = 1; offI = 16'h0003; doCycle(1); brI = 0; offI = '0;
    doCycle(1);
    check("brA_req",  sReq,  1'b1);
    check("brA_addr", sAddr, 16'h0018);
    doCycle(1);
    doCycle(1);
    check("brA_valid", sValid, 1'b1);
    check("brA_pc",    sPc,    16'h0018);

    // Jump while a 3-cycle request is outstanding; the stale word must vanish
    memLatMin = 3; memLatMax = 3; memXor = 16'h1111;
    rstI = 1; doCycle(1); rstI = 0;
    doCycle(1);
    check("jmpB_grant", sReq, 1'b1);
    jmpI = 1; offI = 16'h0100; doCycle(1); jmpI = 0; offI = '0;
    n = 0;
    do begin doCycle(1); n++; end while (!sValid && n < 20);
    check("jmpB_valid", sValid, 1'b1);
    check("jmpB_pc",    sPc,    16'h0200);
    check("jmpB_inst",  sInst,  16'h0200 ^ 16'h1111);

    // Reset with a loaded queue and an outstanding request
    memXor = '0; frzI = 1;
    n = 0;
    while (!(mQ.size() == DEPTH - 1 && mOut) && n < 60) begin doCycle(1); n++; end
    check("rstC_loaded", n < 60, 1'b1);
    rstI = 1; doCycle(1);
    check("rstC_req0", sReq, 1'b0);
    doCycle(1);
    check("rstC_valid", sValid, 1'b0);
    check("rstC_pc",    sPc,    RPC);
    check("rstC_req1",  sReq,   1'b0);
    rstI = 0; frzI = 0;
    doCycle(1);
    check("rstC_restart_req",  sReq,  1'b1);
    check("rstC_restart_addr", sAddr, RPC);
    n = 0;
    do begin doCycle(1); n++; end while (!sValid && n < 20);
    check("rstC_first_pc",   sPc,   RPC);
    check("rstC_first_inst", sInst, RPC);

    // Randomized traffic
    memLatMin = 1; memLatMax = 4; memXor = 16'h5A3C;
    for (int c = 0; c < 1200; c++) begin
      int r;
      r    = int'($urandom_range(0, 99));
      brI  = (r < 6);
      jmpI = (r < 3) || (r == 50);
      offI = 16'($urandom);
      frzI = ($urandom_range(0, 2) == 0);
      gntI = ($urandom_range(0, 3) != 0);
      rstI = ($urandom_range(0, 199) == 0);
      doCycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a decoupled prefetch queue. It generates sequential fetch addresses, issues them to a variable-latency instruction memory over a request/grant/response handshake, and buffers returned words in a FIFO of configurable depth. It presents one instruction plus its PC to decode, honours freeze (stall) from hazard logic, and handles branch/jump redirects with a queue flush and in-flight response squash. It sits between the PC source and the IF/ID pipeline register, replacing the combinational-memory fetch path.

## Interface
- WORD_LEN, 16, width of PC, address, instruction and offset
- PC_STEP, 2, byte increment between sequential instructions
- FIFO_DEPTH, 4, prefetch queue entries (power of two, >= 2)
- RESET_PC, 0, fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- brTaken  in  1  conditional branch taken this cycle
- jump_en  in  1  unconditional jump this cycle
- brOffset  in  WORD_LEN  branch offset / jump target in instruction words
- freeze  in  1  stall; decode does not consume this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  WORD_LEN  fetch address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response word valid
- imem_rsp_data  in  WORD_LEN  response word
- PC  out  WORD_LEN  PC of presented instruction (fetch_pc when queue empty)
- instruction  out  WORD_LEN  head instruction; 0 when queue empty
- inst_valid  out  1  head entry valid

## Operation
- State: fetch_pc, FIFO of {pc, word} (FIFO_DEPTH), count, request FSM.
- FSM states: IDLE (none outstanding), WAIT (one outstanding, keep), DROP (one outstanding, discard). Max one outstanding request.
- IDLE: imem_req = (count < FIFO_DEPTH) and no redirect this cycle; imem_addr = fetch_pc. On imem_req & imem_gnt: tag <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP, -> WAIT.
- WAIT: on imem_rsp_valid, push {tag, imem_rsp_data}, -> IDLE. Space is guaranteed since request was issued only with count < FIFO_DEPTH minus zero outstanding.
- DROP: on imem_rsp_valid, discard word, -> IDLE.
- Pop: inst_valid & ~freeze removes head. Push and pop in same cycle: count unchanged.
- Redirect = jump_en | brTaken; jump_en has priority. Targets: jump -> brOffset << 1; branch -> PC + PC_STEP + (brOffset << 1), where PC is the current output. All sums modulo 2^WORD_LEN; shift drops the MSB.
- On redirect: fetch_pc <= target; FIFO flushed (count <= 0, push/pop suppressed); WAIT -> DROP; IDLE with grant this cycle impossible (req suppressed); DROP stays DROP. Redirect overrides freeze.
- Redirect coincident with imem_rsp_valid in WAIT: response discarded, -> IDLE.
- Reset: fetch_pc = RESET_PC, FIFO empty, FSM IDLE; outputs imem_req 0 during rst, inst_valid 0, instruction 0, PC = RESET_PC. Reset mid-transaction drops the outstanding response (memory is reset by the same rst).

## Timing
- Response earliest one cycle after grant; any later latency tolerated.
- FIFO push visible at outputs next cycle (no bypass).
- Redirect at cycle N with zero-wait memory: imem_req at N+1 with target, response N+2, inst_valid N+3.
- Steady state with zero-wait memory: one instruction per two cycles (single outstanding).
- freeze holds PC/instruction/inst_valid stable; fetch continues until full.
- Full: imem_req low while count == FIFO_DEPTH; resumes the cycle after a pop.

## Test plan
- Reset, zero-wait memory returning word = address: imem_addr 0,2,4…; first inst_valid with PC 0, instruction 0x0000 on cycle 3 after rst release.
- freeze held 10 cycles, FIFO_DEPTH 4: exactly 4 pushes then imem_req low; PC frozen; release -> PCs continue consecutively, none lost or duplicated.
- brTaken with PC 0x0010, brOffset 0x0003: flush, next imem_addr 0x0018, next inst_valid shows PC 0x0018.
- jump_en and brTaken together, brOffset 0x0040: target 0x0080 (jump wins).
- Redirect while request outstanding with 3-cycle latency: stale response discarded, first valid PC equals target.
- rst asserted with full FIFO and outstanding request: next cycle inst_valid 0, PC RESET_PC, imem_req 0; fetch restarts at RESET_PC.
